// File: rtl/jag_strobe_pkg.sv
// Shared sizing constants and helpers for the strobe capture receiver.
package jag_strobe_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 4;

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_PART,
        OCC_FULL
    } occ_e;

    // count must reach DEPTH itself, hence one bit beyond the pointer width
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/strobe_fifo_mem.sv
// Storage array for the capture buffer: one synchronous write port, one asynchronous read port.
module strobe_fifo_mem #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/strobe_capture_rx.sv
// Strobe-loaded capture buffer: accepts one word per ld strobe, presents the oldest word to the reader.
module strobe_capture_rx
    import jag_strobe_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                        sys_clk,
    input  logic                        resetl,
    input  logic                        ld,
    input  logic [WIDTH-1:0]            d,
    output logic [WIDTH-1:0]            q,
    output logic                        q_valid,
    input  logic                        q_rd,
    output logic                        full,
    output logic [cnt_w(DEPTH)-1:0]     count,
    output logic                        ovr,
    input  logic                        ovr_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [WIDTH-1:0] rd_data;
    logic             push;
    logic             pop;
    logic             overrun;
    occ_e             occ;

    always_comb begin
        occ = OCC_PART;
        if (count == '0) begin
            occ = OCC_EMPTY;
        end else if (count == CW'(DEPTH)) begin
            occ = OCC_FULL;
        end
    end

    assign q_valid = (occ != OCC_EMPTY);
    assign full    = (occ == OCC_FULL);

    // A pop frees the slot in the same edge, so a full buffer still accepts ld alongside q_rd
    assign pop     = q_rd && q_valid;
    assign push    = ld && (!full || pop);
    assign overrun = ld && full && !pop;

    always_ff @(posedge sys_clk) begin
        if (!resetl) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovr    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
            if (overrun) begin
                ovr <= 1'b1;
            end else if (ovr_clr) begin
                ovr <= 1'b0;
            end
        end
    end

    strobe_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (sys_clk),
        .we    (push && resetl),
        .waddr (wr_ptr),
        .wdata (d),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    // Stale array contents never leak out while the buffer is empty
    assign q = q_valid ? rd_data : '0;

endmodule

// File: tb/tb_strobe_capture_rx.sv
// Bench for strobe_capture_rx: directed scenarios plus random traffic against a queue model.
module tb_strobe_capture_rx;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int SW    = WIDTH + CW + 3;

    logic             sys_clk = 1'b0;
    logic             resetl  = 1'b0;
    logic             ld      = 1'b0;
    logic [WIDTH-1:0] d       = '0;
    logic [WIDTH-1:0] q;
    logic             q_valid;
    logic             q_rd    = 1'b0;
    logic             full;
    logic [CW-1:0]    count;
    logic             ovr;
    logic             ovr_clr = 1'b0;

    int tests = 0;
    int fails = 0;

    logic [WIDTH-1:0] mq[$];
    logic             movr = 1'b0;

    always #5 sys_clk = ~sys_clk;

    strobe_capture_rx #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .sys_clk (sys_clk),
        .resetl  (resetl),
        .ld      (ld),
        .d       (d),
        .q       (q),
        .q_valid (q_valid),
        .q_rd    (q_rd),
        .full    (full),
        .count   (count),
        .ovr     (ovr),
        .ovr_clr (ovr_clr)
    );

    // One clock: drive inputs, let the edge happen, advance the model, settle to the falling edge.
    task automatic cyc(input logic rl, input logic l, input logic [WIDTH-1:0] dd,
                       input logic r, input logic c);
        bit ovf;
        resetl = rl; ld = l; d = dd; q_rd = r; ovr_clr = c;
        @(posedge sys_clk);
        ovf = 0;
        if (!rl) begin
            mq.delete();
            movr = 1'b0;
        end else begin
            if (r && mq.size() > 0) void'(mq.pop_front());
            if (l) begin
                if (mq.size() < DEPTH) mq.push_back(dd);
                else ovf = 1;
            end
            if (ovf) movr = 1'b1;
            else if (c) movr = 1'b0;
        end
        @(negedge sys_clk);
    endtask

    task automatic idle();
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
    endtask

    function automatic logic [SW-1:0] expv();
        logic [WIDTH-1:0] h;
        h = (mq.size() != 0) ? mq[0] : '0;
        return {h, mq.size() != 0, CW'(mq.size()), mq.size() == DEPTH, movr};
    endfunction

    function automatic logic [SW-1:0] gotv();
        return {q, q_valid, count, full, ovr};
    endfunction

    task automatic test_reset();
        cyc(1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);
        tests++;
        if (gotv() !== {SW{1'b0}}) begin
            fails++; $display("FAIL reset_state got=%h exp=%h", gotv(), {SW{1'b0}});
        end
        cyc(1'b1, 1'b0, '0, 1'b1, 1'b0);
        tests++;
        if ({count, q_valid, ovr} !== '0) begin
            fails++; $display("FAIL rd_when_empty got=%h exp=0", {count, q_valid, ovr});
        end
    endtask

    task automatic test_single();
        cyc(1'b1, 1'b1, 16'h1234, 1'b0, 1'b0);
        tests++;
        if ({q_valid, q, count} !== {1'b1, 16'h1234, CW'(1)}) begin
            fails++; $display("FAIL single_push got=%h exp=%h", {q_valid, q, count}, {1'b1, 16'h1234, CW'(1)});
        end
        cyc(1'b1, 1'b0, '0, 1'b1, 1'b0);
        tests++;
        if ({q_valid, q} !== '0) begin
            fails++; $display("FAIL single_pop got=%h exp=0", {q_valid, q});
        end
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b1, 16'hA000 + 16'(i), 1'b0, 1'b0);
        tests++;
        if ({full, count} !== {1'b1, CW'(DEPTH)}) begin
            fails++; $display("FAIL fill_full got=%h exp=%h", {full, count}, {1'b1, CW'(DEPTH)});
        end
        for (int i = 0; i < DEPTH; i++) begin
            tests++;
            if (q !== 16'hA000 + 16'(i)) begin
                fails++; $display("FAIL drain_order got=%h exp=%h", q, 16'hA000 + 16'(i));
            end
            cyc(1'b1, 1'b0, '0, 1'b1, 1'b0);
        end
        tests++;
        if ({q_valid, q, count} !== '0) begin
            fails++; $display("FAIL drain_empty got=%h exp=0", {q_valid, q, count});
        end
        cyc(1'b1, 1'b1, 16'h0F0F, 1'b1, 1'b0);
        tests++;
        if ({q, count} !== {16'h0F0F, CW'(1)}) begin
            fails++; $display("FAIL ldrd_at_empty got=%h exp=%h", {q, count}, {16'h0F0F, CW'(1)});
        end
        cyc(1'b1, 1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_overrun();
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b1, 16'hC000 + 16'(i), 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 16'hBEEF, 1'b0, 1'b0);
        tests++;
        if ({ovr, count} !== {1'b1, CW'(DEPTH)}) begin
            fails++; $display("FAIL overrun_flag got=%h exp=%h", {ovr, count}, {1'b1, CW'(DEPTH)});
        end
        for (int i = 0; i < DEPTH; i++) begin
            tests++;
            if (q === 16'hBEEF || gotv() !== expv()) begin
                fails++; $display("FAIL overrun_drain got=%h exp=%h", gotv(), expv());
            end
            cyc(1'b1, 1'b0, '0, 1'b1, 1'b0);
        end
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b1);
        tests++;
        if (ovr !== 1'b0) begin
            fails++; $display("FAIL overrun_clear got=%b exp=0", ovr);
        end
    endtask

    task automatic test_full_pushpop();
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b1, 16'hD000 + 16'(i), 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 16'h5555, 1'b1, 1'b0);
        tests++;
        if ({count, ovr, full} !== {CW'(DEPTH), 1'b0, 1'b1}) begin
            fails++; $display("FAIL full_pushpop got=%h exp=%h", {count, ovr, full}, {CW'(DEPTH), 1'b0, 1'b1});
        end
        for (int i = 0; i < DEPTH; i++) begin
            tests++;
            if (gotv() !== expv()) begin
                fails++; $display("FAIL full_pushpop_drain got=%h exp=%h", gotv(), expv());
            end
            if (i == DEPTH - 1) begin
                tests++;
                if (q !== 16'h5555) begin
                    fails++; $display("FAIL full_pushpop_last got=%h exp=5555", q);
                end
            end
            cyc(1'b1, 1'b0, '0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_ovr_clr();
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b1, 16'h7000 + 16'(i), 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 16'h7777, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 16'h7778, 1'b0, 1'b1);
        tests++;
        if (ovr !== 1'b1) begin
            fails++; $display("FAIL ovr_set_wins got=%b exp=1", ovr);
        end
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b1);
        tests++;
        if (ovr !== 1'b0) begin
            fails++; $display("FAIL ovr_clr_alone got=%b exp=0", ovr);
        end
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 16'h9000 + 16'(i), 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 16'h9999, 1'b1, 1'b0);
        tests++;
        if ({count, q_valid, q} !== '0) begin
            fails++; $display("FAIL reset_mid got=%h exp=0", {count, q_valid, q});
        end
        cyc(1'b1, 1'b1, 16'hE000, 1'b0, 1'b0);
        tests++;
        if ({count, q} !== {CW'(1), 16'hE000}) begin
            fails++; $display("FAIL reset_mid_push got=%h exp=%h", {count, q}, {CW'(1), 16'hE000});
        end
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b1, 1'b1, 16'hE000 + 16'(i), 1'b1, 1'b0);
            tests++;
            if (q !== 16'hE000 + 16'(i) || gotv() !== expv()) begin
                fails++; $display("FAIL wrap_order got=%h exp=%h", gotv(), expv());
            end
        end
        cyc(1'b1, 1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 39) != 0), $urandom_range(0, 1) == 1, 16'($urandom),
                ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0));
            tests++;
            if (gotv() !== expv()) begin
                fails++; $display("FAIL random[%0d] got=%h exp=%h", i, gotv(), expv());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_drain();
        test_overrun();
        test_full_pushpop();
        test_ovr_clr();
        test_reset_mid();
        test_random();
        idle();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
